// File: rtl/mem_arbiter_if.sv
// CPU-side and RAM-side bus of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the requests and models the RAM.
interface mem_arbiter_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imem_load;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_store;
  logic        dhit;
  logic [31:0] dmem_load;
  logic        dmem_fault;
  logic [31:0] ram_addr;
  logic        ram_ren;
  logic        ram_wen;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  modport slave (
    input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width,
           dmem_store, ram_rdata, ram_ready,
    output ihit, imem_load, dhit, dmem_load, dmem_fault,
           ram_addr, ram_ren, ram_wen, ram_be, ram_wdata
  );

  modport master (
    output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width,
           dmem_store, ram_rdata, ram_ready,
    input  ihit, imem_load, dhit, dmem_load, dmem_fault,
           ram_addr, ram_ren, ram_wen, ram_be, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory front end: arbitrates instruction fetches and data
// loads/stores onto one variable-latency RAM port, steers byte lanes and
// returns one-cycle registered hit pulses. Every output is a flop.
module mem_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic           clk,
  input logic           nrst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        ihit_r, ihit_s;
  logic        dhit_r, dhit_s;
  logic        fault_r, fault_s;
  logic [31:0] imem_load_r, imem_load_s;
  logic [31:0] dmem_load_r, dmem_load_s;
  logic [31:0] ram_addr_r, ram_addr_s;
  logic        ram_ren_r, ram_ren_s;
  logic        ram_wen_r, ram_wen_s;
  logic [3:0]  ram_be_r, ram_be_s;
  logic [31:0] ram_wdata_r, ram_wdata_s;
  logic [1:0]  cap_lo_r, cap_lo_s;
  logic [1:0]  cap_width_r, cap_width_s;
  logic        cap_wr_r, cap_wr_s;
  logic        data_req_s;
  logic        data_wins_s;
  logic        unused_s;

  // Fetch addresses are word aligned; the low bits carry no information.
  assign unused_s = ^bus.imem_addr[1:0];

  // Byte enables for a store of the given width at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      2'b00:   store_be = 4'b0001 << lo;
      2'b01:   store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could occupy.
  function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] st);
    case (width)
      2'b00:   store_lanes = {4{st[7:0]}};
      2'b01:   store_lanes = {2{st[15:0]}};
      default: store_lanes = st;
    endcase
  endfunction

  // Right-align the addressed lanes of a RAM word and zero-fill above width.
  function automatic logic [31:0] load_extract(input logic [1:0] width, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (width)
      2'b00:   load_extract = {24'h000000, sh[7:0]};
      2'b01:   load_extract = {16'h0000, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Half on an odd byte or word off a word boundary cannot be served.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    misaligned = ((width == 2'b01) && lo[0]) || (width[1] && (lo != 2'b00));
  endfunction

  assign data_req_s  = bus.dmem_ren | bus.dmem_wen;
  assign data_wins_s = data_req_s & ((DATA_PRIORITY == 1'b1) | ~bus.imem_ren);

  // Next-state and next-output logic; strobes hold, hit pulses default low.
  always_comb begin
    state_s     = state_r;
    ihit_s      = 1'b0;
    dhit_s      = 1'b0;
    fault_s     = 1'b0;
    imem_load_s = imem_load_r;
    dmem_load_s = dmem_load_r;
    ram_addr_s  = ram_addr_r;
    ram_ren_s   = ram_ren_r;
    ram_wen_s   = ram_wen_r;
    ram_be_s    = ram_be_r;
    ram_wdata_s = ram_wdata_r;
    cap_lo_s    = cap_lo_r;
    cap_width_s = cap_width_r;
    cap_wr_s    = cap_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (data_wins_s) begin
          if (misaligned(bus.dmem_width, bus.dmem_addr[1:0])) begin
            state_s = ST_RESP;
            dhit_s  = 1'b1;
            fault_s = 1'b1;
          end else begin
            state_s     = ST_DBUSY;
            cap_lo_s    = bus.dmem_addr[1:0];
            cap_width_s = bus.dmem_width;
            cap_wr_s    = bus.dmem_wen;
            ram_addr_s  = {bus.dmem_addr[31:2], 2'b00};
            ram_ren_s   = ~bus.dmem_wen;
            ram_wen_s   = bus.dmem_wen;
            if (bus.dmem_wen) begin
              ram_be_s    = store_be(bus.dmem_width, bus.dmem_addr[1:0]);
              ram_wdata_s = store_lanes(bus.dmem_width, bus.dmem_store);
            end else begin
              ram_be_s    = 4'b1111;
            end
          end
        end else if (bus.imem_ren) begin
          state_s    = ST_IBUSY;
          ram_addr_s = {bus.imem_addr[31:2], 2'b00};
          ram_ren_s  = 1'b1;
          ram_wen_s  = 1'b0;
          ram_be_s   = 4'b1111;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_IBUSY: begin
        if (bus.ram_ready) begin
          state_s     = ST_RESP;
          ram_ren_s   = 1'b0;
          ram_wen_s   = 1'b0;
          imem_load_s = bus.ram_rdata;
          ihit_s      = 1'b1;
        end else begin
          state_s = ST_IBUSY;
        end
      end
      ST_DBUSY: begin
        if (bus.ram_ready) begin
          state_s   = ST_RESP;
          ram_ren_s = 1'b0;
          ram_wen_s = 1'b0;
          dhit_s    = 1'b1;
          if (cap_wr_r) begin
            dmem_load_s = 32'h00000000;
          end else begin
            dmem_load_s = load_extract(cap_width_r, cap_lo_r, bus.ram_rdata);
          end
        end else begin
          state_s = ST_DBUSY;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        ram_ren_s = 1'b0;
        ram_wen_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      ihit_r      <= 1'b0;
      dhit_r      <= 1'b0;
      fault_r     <= 1'b0;
      imem_load_r <= 32'h00000000;
      dmem_load_r <= 32'h00000000;
      ram_addr_r  <= 32'h00000000;
      ram_ren_r   <= 1'b0;
      ram_wen_r   <= 1'b0;
      ram_be_r    <= 4'b0000;
      ram_wdata_r <= 32'h00000000;
      cap_lo_r    <= 2'b00;
      cap_width_r <= 2'b00;
      cap_wr_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      ihit_r      <= ihit_s;
      dhit_r      <= dhit_s;
      fault_r     <= fault_s;
      imem_load_r <= imem_load_s;
      dmem_load_r <= dmem_load_s;
      ram_addr_r  <= ram_addr_s;
      ram_ren_r   <= ram_ren_s;
      ram_wen_r   <= ram_wen_s;
      ram_be_r    <= ram_be_s;
      ram_wdata_r <= ram_wdata_s;
      cap_lo_r    <= cap_lo_s;
      cap_width_r <= cap_width_s;
      cap_wr_r    <= cap_wr_s;
    end
  end

  assign bus.ihit       = ihit_r;
  assign bus.dhit       = dhit_r;
  assign bus.dmem_fault = fault_r;
  assign bus.imem_load  = imem_load_r;
  assign bus.dmem_load  = dmem_load_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_ren    = ram_ren_r;
  assign bus.ram_wen    = ram_wen_r;
  assign bus.ram_be     = ram_be_r;
  assign bus.ram_wdata  = ram_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled on
// the falling edge; "cycle k" is the k-th clock period after a request is
// presented.
module tb_mem_arbiter;

  logic clk;
  logic nrst;
  int   tests_run;
  int   tests_failed;

  mem_arbiter_if bus_if ();

  mem_arbiter #(.DATA_PRIORITY(1'b1)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.imem_ren   = 1'b0;
    bus_if.imem_addr  = 32'h00000000;
    bus_if.dmem_ren   = 1'b0;
    bus_if.dmem_wen   = 1'b0;
    bus_if.dmem_addr  = 32'h00000000;
    bus_if.dmem_width = 2'b10;
    bus_if.dmem_store = 32'h00000000;
    bus_if.ram_rdata  = 32'h00000000;
    bus_if.ram_ready  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    idle_inputs();
    nrst = 1'b0;
    #12;
    got = {27'd0, bus_if.ihit, bus_if.dhit, bus_if.dmem_fault, bus_if.ram_ren, bus_if.ram_wen};
    tests_run++;
    if (got !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%h want=%h", got, 32'd0);
    end
    got = bus_if.ram_addr | bus_if.ram_wdata | bus_if.imem_load | bus_if.dmem_load | {28'd0, bus_if.ram_be};
    tests_run++;
    if (got !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_buses got=%h want=%h", got, 32'd0);
    end
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus_if.ram_ready = 1'b1;
    bus_if.ram_rdata = 32'h00A00093;
    bus_if.imem_ren  = 1'b1;
    bus_if.imem_addr = 32'h00000104;
    tick(); // cycle 1
    tests_run++;
    if (bus_if.ram_ren !== 1'b1 || bus_if.ram_addr !== 32'h00000104 || bus_if.ram_be !== 4'b1111) begin
      tests_failed++;
      $display("FAIL fetch_strobe ren=%b addr=%h be=%b want ren=1 addr=00000104 be=1111",
               bus_if.ram_ren, bus_if.ram_addr, bus_if.ram_be);
    end
    tests_run++;
    if (bus_if.ihit !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_early_hit got=%b want=0", bus_if.ihit);
    end
    tick(); // cycle 2
    tests_run++;
    if (bus_if.ihit !== 1'b1 || bus_if.imem_load !== 32'h00A00093 || bus_if.ram_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_hit ihit=%b load=%h ren=%b want ihit=1 load=00a00093 ren=0",
               bus_if.ihit, bus_if.imem_load, bus_if.ram_ren);
    end
    bus_if.imem_ren = 1'b0;
    tick(); // cycle 3
    tests_run++;
    if (bus_if.ihit !== 1'b0 || bus_if.imem_load !== 32'h00A00093) begin
      tests_failed++;
      $display("FAIL fetch_pulse ihit=%b load=%h want ihit=0 load=00a00093", bus_if.ihit, bus_if.imem_load);
    end
  endtask

  task automatic test_priority();
    bus_if.ram_ready  = 1'b1;
    bus_if.ram_rdata  = 32'h11223344;
    bus_if.imem_ren   = 1'b1;
    bus_if.imem_addr  = 32'h00000080;
    bus_if.dmem_ren   = 1'b1;
    bus_if.dmem_addr  = 32'h00000100;
    bus_if.dmem_width = 2'b10;
    tick(); // cycle 1
    tests_run++;
    if (bus_if.ram_ren !== 1'b1 || bus_if.ram_addr !== 32'h00000100) begin
      tests_failed++;
      $display("FAIL prio_data_first ren=%b addr=%h want ren=1 addr=00000100", bus_if.ram_ren, bus_if.ram_addr);
    end
    tick(); // cycle 2
    tests_run++;
    if (bus_if.dhit !== 1'b1 || bus_if.ihit !== 1'b0 || bus_if.dmem_load !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL prio_dhit dhit=%b ihit=%b load=%h want dhit=1 ihit=0 load=11223344",
               bus_if.dhit, bus_if.ihit, bus_if.dmem_load);
    end
    bus_if.dmem_ren  = 1'b0;
    bus_if.ram_rdata = 32'h55667788;
    tick(); // cycle 3: back in IDLE, fetch accepted here
    tests_run++;
    if (bus_if.ram_ren !== 1'b0 || bus_if.dhit !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_resp_gap ren=%b dhit=%b want ren=0 dhit=0", bus_if.ram_ren, bus_if.dhit);
    end
    tick(); // cycle 4
    tests_run++;
    if (bus_if.ram_ren !== 1'b1 || bus_if.ram_addr !== 32'h00000080 || bus_if.ihit !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_fetch_strobe ren=%b addr=%h ihit=%b want ren=1 addr=00000080 ihit=0",
               bus_if.ram_ren, bus_if.ram_addr, bus_if.ihit);
    end
    tick(); // cycle 5
    tests_run++;
    if (bus_if.ihit !== 1'b1 || bus_if.imem_load !== 32'h55667788) begin
      tests_failed++;
      $display("FAIL prio_ihit ihit=%b load=%h want ihit=1 load=55667788", bus_if.ihit, bus_if.imem_load);
    end
    bus_if.imem_ren = 1'b0;
    tick();
  endtask

  task automatic test_store_lanes();
    // byte 0xAB at 0x203, RAM not ready for one cycle
    bus_if.ram_ready  = 1'b0;
    bus_if.dmem_wen   = 1'b1;
    bus_if.dmem_addr  = 32'h00000203;
    bus_if.dmem_width = 2'b00;
    bus_if.dmem_store = 32'h123456AB;
    tick(); // cycle 1
    tests_run++;
    if (bus_if.ram_wen !== 1'b1 || bus_if.ram_ren !== 1'b0 || bus_if.ram_be !== 4'b1000 ||
        bus_if.ram_wdata !== 32'hABABABAB || bus_if.ram_addr !== 32'h00000200) begin
      tests_failed++;
      $display("FAIL store_byte wen=%b ren=%b be=%b wdata=%h addr=%h want 1 0 1000 abababab 00000200",
               bus_if.ram_wen, bus_if.ram_ren, bus_if.ram_be, bus_if.ram_wdata, bus_if.ram_addr);
    end
    bus_if.ram_ready = 1'b1;
    tick(); // cycle 2
    tests_run++;
    if (bus_if.dhit !== 1'b1 || bus_if.dmem_load !== 32'h00000000 || bus_if.ram_wen !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_byte_done dhit=%b load=%h wen=%b want dhit=1 load=00000000 wen=0",
               bus_if.dhit, bus_if.dmem_load, bus_if.ram_wen);
    end
    bus_if.dmem_wen = 1'b0;
    tick();
    // half 0xBEEF at 0x202
    bus_if.dmem_wen   = 1'b1;
    bus_if.dmem_addr  = 32'h00000202;
    bus_if.dmem_width = 2'b01;
    bus_if.dmem_store = 32'h0000BEEF;
    tick(); // cycle 1
    tests_run++;
    if (bus_if.ram_be !== 4'b1100 || bus_if.ram_wdata !== 32'hBEEFBEEF || bus_if.ram_addr !== 32'h00000200) begin
      tests_failed++;
      $display("FAIL store_half be=%b wdata=%h addr=%h want 1100 beefbeef 00000200",
               bus_if.ram_be, bus_if.ram_wdata, bus_if.ram_addr);
    end
    tick(); // cycle 2
    tests_run++;
    if (bus_if.dhit !== 1'b1) begin
      tests_failed++;
      $display("FAIL store_half_done dhit=%b want 1", bus_if.dhit);
    end
    bus_if.dmem_wen = 1'b0;
    tick();
  endtask

  task automatic test_load_delayed();
    bus_if.ram_ready  = 1'b0;
    bus_if.ram_rdata  = 32'h80011234;
    bus_if.dmem_ren   = 1'b1;
    bus_if.dmem_addr  = 32'h00000206;
    bus_if.dmem_width = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        // fields change while busy; the captured request must be used
        bus_if.dmem_addr  = 32'h00000301;
        bus_if.dmem_width = 2'b10;
      end
      if (c == 4) bus_if.ram_ready = 1'b1;
      tests_run++;
      if (bus_if.ram_ren !== 1'b1 || bus_if.dhit !== 1'b0 || bus_if.ram_addr !== 32'h00000204) begin
        tests_failed++;
        $display("FAIL load_wait c=%0d ren=%b dhit=%b addr=%h want ren=1 dhit=0 addr=00000204",
                 c, bus_if.ram_ren, bus_if.dhit, bus_if.ram_addr);
      end
    end
    tick(); // cycle 5
    tests_run++;
    if (bus_if.dhit !== 1'b1 || bus_if.dmem_load !== 32'h00008001 || bus_if.ram_ren !== 1'b0 ||
        bus_if.dmem_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_half dhit=%b load=%h ren=%b fault=%b want 1 00008001 0 0",
               bus_if.dhit, bus_if.dmem_load, bus_if.ram_ren, bus_if.dmem_fault);
    end
    bus_if.dmem_ren = 1'b0;
    bus_if.ram_ready = 1'b1;
    tick();
    // byte load at 0x203 picks the top lane
    bus_if.ram_rdata  = 32'hAB000000;
    bus_if.dmem_ren   = 1'b1;
    bus_if.dmem_addr  = 32'h00000203;
    bus_if.dmem_width = 2'b00;
    tick();
    tick();
    tests_run++;
    if (bus_if.dhit !== 1'b1 || bus_if.dmem_load !== 32'h000000AB) begin
      tests_failed++;
      $display("FAIL load_byte dhit=%b load=%h want 1 000000ab", bus_if.dhit, bus_if.dmem_load);
    end
    bus_if.dmem_ren = 1'b0;
    tick();
  endtask

  task automatic test_fault();
    bus_if.ram_ready  = 1'b1;
    bus_if.dmem_ren   = 1'b1;
    bus_if.dmem_addr  = 32'h00000301;
    bus_if.dmem_width = 2'b10;
    tick(); // cycle 1
    tests_run++;
    if (bus_if.dhit !== 1'b1 || bus_if.dmem_fault !== 1'b1 || bus_if.ram_ren !== 1'b0 ||
        bus_if.dmem_load !== 32'h000000AB) begin
      tests_failed++;
      $display("FAIL fault_word dhit=%b fault=%b ren=%b load=%h want 1 1 0 000000ab",
               bus_if.dhit, bus_if.dmem_fault, bus_if.ram_ren, bus_if.dmem_load);
    end
    bus_if.dmem_ren = 1'b0;
    tick(); // cycle 2
    tests_run++;
    if (bus_if.dhit !== 1'b0 || bus_if.dmem_fault !== 1'b0 || bus_if.ram_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_pulse dhit=%b fault=%b ren=%b want 0 0 0",
               bus_if.dhit, bus_if.dmem_fault, bus_if.ram_ren);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] got;
    bus_if.ram_ready  = 1'b0;
    bus_if.dmem_ren   = 1'b1;
    bus_if.dmem_addr  = 32'h00000100;
    bus_if.dmem_width = 2'b10;
    tick(); // cycle 1: DBUSY
    tests_run++;
    if (bus_if.ram_ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_ren got=%b want 1", bus_if.ram_ren);
    end
    #1 nrst = 1'b0;
    #1;
    tests_run++;
    if (bus_if.ram_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_drop ren=%b want 0", bus_if.ram_ren);
    end
    bus_if.dmem_ren = 1'b0;
    bus_if.ram_ready = 1'b1;
    @(negedge clk);
    got = bus_if.ram_addr | bus_if.ram_wdata | bus_if.imem_load | bus_if.dmem_load |
          {27'd0, bus_if.ram_be, bus_if.dhit} | {30'd0, bus_if.ihit, bus_if.dmem_fault};
    tests_run++;
    if (got !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_outputs got=%h want=%h", got, 32'd0);
    end
    nrst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus_if.dhit !== 1'b0 || bus_if.ram_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_hit dhit=%b ren=%b want 0 0", bus_if.dhit, bus_if.ram_ren);
    end
    bus_if.ram_rdata = 32'hDEADBEEF;
    bus_if.imem_ren  = 1'b1;
    bus_if.imem_addr = 32'h00000010;
    tick();
    tick();
    tests_run++;
    if (bus_if.ihit !== 1'b1 || bus_if.imem_load !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rst_fetch_after ihit=%b load=%h want 1 deadbeef", bus_if.ihit, bus_if.imem_load);
    end
    bus_if.imem_ren = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_store_lanes();
    test_load_delayed();
    test_fault();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
